// File: rtl/shl_rol_seq.sv
// Iterative left shifter/rotator: SLL or ROL, one bit position per clock.
// Ports: clk, rst (sync, active high), start/mode/si/sv in; so/busy/done out.
module shl_rol_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] si,
    input  logic [SHW-1:0]   sv,
    output logic [WIDTH-1:0] so,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] so_q;
    logic [WIDTH-1:0] so_d;
    logic [SHW-1:0]   cnt_q;
    logic             mode_q;
    logic             busy_q;
    logic             done_q;

    // One-position step; ROL feeds the old MSB back into the LSB.
    always_comb begin
        so_d = {so_q[WIDTH-2:0], 1'b0};
        if (mode_q) begin
            so_d[0] = so_q[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            so_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        so_q   <= si;
                        mode_q <= mode;
                        cnt_q  <= sv;
                        // A zero shift skips straight to the result cycle.
                        if (sv != '0) begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    so_q  <= so_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign so   = so_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shl_rol_seq.sv
// Directed-vector bench for shl_rol_seq.
// Ports driven #1 after each rising edge and checked there.
module tb_shl_rol_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] si;
    logic [3:0]  sv;
    logic [15:0] so;
    logic        busy;
    logic        done;

    int n_chk;
    int n_err;

    shl_rol_seq #(.WIDTH(16), .SHW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .si    (si),
        .sv    (sv),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (C0), expect busy C1..Cn, done in C(n+1),
    // then IDLE with so held.
    task automatic run_op(input string tag, input logic m,
                          input logic [15:0] a, input logic [3:0] n,
                          input logic [15:0] exp, input bit tog);
        start = 1'b1;
        mode  = m;
        si    = a;
        sv    = n;
        tick();
        start = 1'b0;
        for (int k = 1; k <= int'(n); k++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            if (tog) begin
                start = 1'($urandom);
                mode  = 1'($urandom);
                si    = 16'($urandom);
                sv    = 4'($urandom);
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_so"}, so, exp);
        chk({tag, "_busy_at_done"}, busy, 0);
        tick();
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_hold_so"}, so, exp);
    endtask

    int pulses;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        si    = '0;
        sv    = '0;
        tick();
        tick();
        chk("rst_so", so, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        run_op("sll1", 1'b0, 16'h8001, 4'd1, 16'h0002, 1'b0);
        run_op("rol1", 1'b1, 16'h8001, 4'd1, 16'h0003, 1'b0);
        run_op("rol15", 1'b1, 16'hF00F, 4'd15, 16'hF807, 1'b0);
        run_op("sll15", 1'b0, 16'h0001, 4'd15, 16'h8000, 1'b0);
        run_op("sll4", 1'b0, 16'h1234, 4'd4, 16'h2340, 1'b0);
        run_op("sll4_tog", 1'b0, 16'h1234, 4'd4, 16'h2340, 1'b1);
        run_op("sv0", 1'b1, 16'hBEEF, 4'd0, 16'hBEEF, 1'b0);

        // Back-to-back: second start taken in the DONE cycle.
        start = 1'b1;
        mode  = 1'b0;
        si    = 16'h0001;
        sv    = 4'd2;
        tick();
        start = 1'b0;
        tick();
        chk("b2b_busy2", busy, 1);
        tick();
        chk("b2b_done1", done, 1);
        chk("b2b_so1", so, 16'h0004);
        start = 1'b1;
        si    = 16'h00FF;
        sv    = 4'd8;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("b2b_busy", busy, 1);
            tick();
        end
        chk("b2b_done2", done, 1);
        chk("b2b_so2", so, 16'hFF00);
        tick();
        chk("b2b_idle", done, 0);

        // Reset in C4 of a 10-step rotate.
        start = 1'b1;
        mode  = 1'b1;
        si    = 16'h1234;
        sv    = 4'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_so", so, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) pulses++;
            tick();
        end
        chk("abort_no_done", pulses, 0);
        run_op("after_rst", 1'b1, 16'h1234, 4'd10, 16'hD048, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
